// File: rtl/c11_bist_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : c11_bist_engine_pkg
//  Description : Shared types, constants and next-state helpers for the
//                c11 BIST engine (LFSR pattern generator + 16-bit MISR).
//  Revision    : 1.0  initial release
// ============================================================================
package c11_bist_engine_pkg;

    // Datapath widths
    localparam int PAT_W = 10;
    localparam int SIG_W = 16;
    localparam int CNT_W = PAT_W + 1;   // one extra bit so a count of 0 can mean 1024

    // LFSR feedback taps (x^10 + x^7 + 1, period 1023)
    localparam int LFSR_TAP_HI = 9;
    localparam int LFSR_TAP_LO = 6;

    // Safe LFSR value used after reset and in place of an all-zero seed
    localparam logic [PAT_W-1:0] LFSR_RESET = 10'h001;

    // MISR feedback polynomial (CRC-16-CCITT)
    localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

    // Run controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

    // One LFSR step: shift left, feed back the XOR of the two taps into bit 0
    function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] l);
        return {l[PAT_W-2:0], l[LFSR_TAP_HI] ^ l[LFSR_TAP_LO]};
    endfunction

    // One MISR step folding a single response bit into the signature
    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] m,
                                                   input logic             d);
        return {m[SIG_W-2:0], 1'b0}
             ^ (m[SIG_W-1] ? MISR_POLY : {SIG_W{1'b0}})
             ^ {{(SIG_W-1){1'b0}}, d};
    endfunction

endpackage
`default_nettype wire

// File: rtl/c11_bist_engine_misr16.sv
`default_nettype none
// ============================================================================
//  Module      : c11_misr16
//  Description : 16-bit single-input signature register. Synchronous clear
//                has priority over the fold enable.
//  Revision    : 1.0  initial release
// ============================================================================
module c11_misr16
    import c11_bist_engine_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    // Signature register: clear on a new run, fold one response bit when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_next(sig, din);
        end
    end

endmodule
`default_nettype wire

// File: rtl/c11_bist_engine.sv
`default_nettype none
// ============================================================================
//  Module      : c11_bist_engine
//  Description : Logic BIST run controller. Drives LFSR patterns into a
//                10-input circuit under test, compresses its single-bit
//                response in a 16-bit MISR, and compares the final
//                signature with a golden value.
//  Revision    : 1.0  initial release
// ============================================================================
module c11_bist_engine
    import c11_bist_engine_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [PAT_W-1:0] seed_i,
    input  logic [PAT_W-1:0] count_i,
    input  logic [SIG_W-1:0] golden_i,
    output logic [PAT_W-1:0] pat_o,
    output logic             pat_valid_o,
    input  logic             resp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [SIG_W-1:0] sig_o
);

    bist_state_t      state;
    logic [PAT_W-1:0] lfsr;
    logic [CNT_W-1:0] remaining;     // patterns still to apply, including the current one
    logic [SIG_W-1:0] golden_q;
    logic             resp_q;        // response captured at the last RUN edge
    logic             cap_pending;   // resp_q holds a capture not yet folded into the MISR
    logic             pat_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic             start_accept;
    logic             misr_en;
    logic [SIG_W-1:0] sig;

    // A start is honoured only from IDLE; abort is meaningless there, so start wins
    assign start_accept = (state == ST_IDLE) && start_i;

    // Fold the previous capture one cycle later; an abort freezes the signature
    assign misr_en = cap_pending && !abort_i &&
                     ((state == ST_RUN) || (state == ST_DRAIN));

    // Run controller: state, LFSR, pattern counter, response capture and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            lfsr        <= LFSR_RESET;
            remaining   <= '0;
            golden_q    <= '0;
            resp_q      <= 1'b0;
            cap_pending <= 1'b0;
            pat_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_accept) begin
                        lfsr        <= (seed_i == '0) ? LFSR_RESET : seed_i;
                        remaining   <= {(count_i == '0), count_i};
                        golden_q    <= golden_i;
                        pass_q      <= 1'b0;
                        cap_pending <= 1'b0;
                        pat_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (abort_i) begin
                        pat_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        cap_pending <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        resp_q      <= resp_i;
                        cap_pending <= 1'b1;
                        lfsr        <= lfsr_next(lfsr);
                        remaining   <= remaining - 1'b1;
                        // This edge applies the last pattern
                        if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            pat_valid_q <= 1'b0;
                            state       <= ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (abort_i) begin
                        busy_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        cap_pending <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        // The MISR takes its final fold on this same edge, so
                        // compare against the value it is about to hold
                        pass_q      <= (misr_next(sig, resp_q) == golden_q);
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        cap_pending <= 1'b0;
                        state       <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    c11_misr16 u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_accept),
        .en    (misr_en),
        .din   (resp_q),
        .sig   (sig)
    );

    // Pattern bus is forced to zero whenever no live pattern is presented
    assign pat_o       = pat_valid_q ? lfsr : '0;
    assign pat_valid_o = pat_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign sig_o       = sig;

endmodule
`default_nettype wire

// File: tb/tb_c11_bist_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_c11_bist_engine
//  Description : Self-checking bench for c11_bist_engine: table of directed
//                runs plus hand-written mid-run start, abort and reset cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_c11_bist_engine;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        abort_i;
    logic [9:0]  seed_i;
    logic [9:0]  count_i;
    logic [15:0] golden_i;
    logic [9:0]  pat_o;
    logic        pat_valid_o;
    logic        resp_i;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic [15:0] sig_o;

    // Circuit-under-test stand-in: either a constant level or parity of masked pattern bits
    logic        use_cut;
    logic        resp_lvl;
    logic [9:0]  cut_mask;
    assign resp_i = use_cut ? ^(pat_o & cut_mask) : resp_lvl;

    int n_vec;
    int n_fail;

    c11_bist_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .seed_i      (seed_i),
        .count_i     (count_i),
        .golden_i    (golden_i),
        .pat_o       (pat_o),
        .pat_valid_o (pat_valid_o),
        .resp_i      (resp_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .sig_o       (sig_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  seed;
        logic [9:0]  count;
        logic [15:0] golden;
        logic        cut;
        logic [9:0]  mask;
        logic        lvl;
        logic [9:0]  exp_first;
        logic [9:0]  exp_last;
        int          exp_npat;
        logic [15:0] exp_sig;
        logic        exp_pass;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] lfsr_step(input logic [9:0] l);
        return {l[8:0], l[9] ^ l[6]};
    endfunction

    // Apply one run; optionally pulse start_i with different inputs in cycle inj_cyc
    task automatic run(input logic [9:0] seed, input logic [9:0] count,
                       input logic [15:0] golden, input int inj_cyc,
                       output logic [9:0] first_p, output logic [9:0] last_p,
                       output int npat, output int done_cyc,
                       output logic [15:0] sig_at_done, output logic pass_at_done,
                       output int seq_err, output int ndone);
        int          n;
        logic [9:0]  model;
        first_p = '0; last_p = '0; npat = 0; done_cyc = 0;
        sig_at_done = '0; pass_at_done = 1'b0; seq_err = 0; ndone = 0;
        n     = (count == 10'd0) ? 1024 : int'(count);
        model = (seed == 10'd0) ? 10'h001 : seed;
        seed_i = seed; count_i = count; golden_i = golden; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int cyc = 1; cyc <= n + 12; cyc++) begin
            if (pat_valid_o) begin
                if (npat == 0) first_p = pat_o;
                last_p = pat_o;
                npat++;
                if (pat_o !== model) seq_err++;
                model = lfsr_step(model);
            end else if (pat_o !== 10'd0) begin
                seq_err++;
            end
            if (cyc <= n + 2) begin
                if (busy_o !== (cyc <= n + 1)) seq_err++;
                if (pat_valid_o !== (cyc <= n)) seq_err++;
            end
            if (done_o) begin
                ndone++;
                if (done_cyc == 0) begin
                    done_cyc = cyc; sig_at_done = sig_o; pass_at_done = pass_o;
                end
            end
            if (cyc == inj_cyc) begin
                start_i = 1'b1; seed_i = 10'h3FF; count_i = 10'd5; golden_i = ~golden;
            end
            tick();
            start_i = 1'b0;
        end
    endtask

    logic [9:0]  f_p, l_p;
    int          np, dc, se, nd;
    logic [15:0] sd;
    logic        pd;

    initial begin
        n_vec = 0; n_fail = 0;
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        seed_i = '0; count_i = '0; golden_i = '0;
        use_cut = 1'b0; resp_lvl = 1'b0; cut_mask = '0;

        //                seed    cnt     golden    cut  mask    lvl  first   last    npat  sig       pass
        vecs[0] = '{10'h001, 10'd2,  16'h0003, 1'b0, 10'h000, 1'b1, 10'h001, 10'h002, 2,    16'h0003, 1'b1};
        vecs[1] = '{10'h000, 10'd1,  16'h0001, 1'b0, 10'h000, 1'b0, 10'h001, 10'h001, 1,    16'h0000, 1'b0};
        vecs[2] = '{10'h001, 10'd3,  16'h0007, 1'b0, 10'h000, 1'b1, 10'h001, 10'h004, 3,    16'h0007, 1'b1};
        vecs[3] = '{10'h200, 10'd2,  16'h0000, 1'b0, 10'h000, 1'b1, 10'h200, 10'h001, 2,    16'h0003, 1'b0};
        vecs[4] = '{10'h001, 10'd3,  16'h0004, 1'b1, 10'h001, 1'b0, 10'h001, 10'h004, 3,    16'h0004, 1'b1};
        vecs[5] = '{10'h001, 10'd17, 16'hEFDE, 1'b0, 10'h000, 1'b1, 10'h001, 10'h244, 17,   16'hEFDE, 1'b1};
        vecs[6] = '{10'h155, 10'd0,  16'h0000, 1'b0, 10'h000, 1'b0, 10'h155, 10'h155, 1024, 16'h0000, 1'b1};

        // Reset state
        tick(); tick();
        check("reset_outputs", {pat_o, pat_valid_o, busy_o, done_o, pass_o, sig_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed runs
        for (int i = 0; i < 7; i++) begin
            use_cut = vecs[i].cut; cut_mask = vecs[i].mask; resp_lvl = vecs[i].lvl;
            run(vecs[i].seed, vecs[i].count, vecs[i].golden, 0, f_p, l_p, np, dc, sd, pd, se, nd);
            check($sformatf("v%0d_first_pat", i), 32'(f_p), 32'(vecs[i].exp_first));
            check($sformatf("v%0d_last_pat",  i), 32'(l_p), 32'(vecs[i].exp_last));
            check($sformatf("v%0d_npat",      i), 32'(np),  32'(vecs[i].exp_npat));
            check($sformatf("v%0d_done_cyc",  i), 32'(dc),  32'(vecs[i].exp_npat + 2));
            check($sformatf("v%0d_ndone",     i), 32'(nd),  32'd1);
            check($sformatf("v%0d_seq_err",   i), 32'(se),  32'd0);
            check($sformatf("v%0d_sig",       i), 32'(sd),  32'(vecs[i].exp_sig));
            check($sformatf("v%0d_pass",      i), 32'(pd),  32'(vecs[i].exp_pass));
            check($sformatf("v%0d_pass_hold", i), 32'(pass_o), 32'(vecs[i].exp_pass));
            check($sformatf("v%0d_sig_hold",  i), 32'(sig_o),  32'(vecs[i].exp_sig));
        end

        // start_i mid-RUN with a new seed/count/golden is ignored
        use_cut = 1'b0; resp_lvl = 1'b1;
        run(10'h001, 10'd10, 16'h03FF, 3, f_p, l_p, np, dc, sd, pd, se, nd);
        check("midstart_last_pat", 32'(l_p), 32'h204);
        check("midstart_npat",     32'(np),  32'd10);
        check("midstart_done_cyc", 32'(dc),  32'd12);
        check("midstart_ndone",    32'(nd),  32'd1);
        check("midstart_seq_err",  32'(se),  32'd0);
        check("midstart_sig",      32'(sd),  32'h03FF);
        check("midstart_pass",     32'(pd),  32'd1);

        // abort_i in cycle 3 of a count=10 run
        seed_i = 10'h001; count_i = 10'd10; golden_i = 16'h0001; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_valid", 32'(pat_valid_o), 32'd0);
        check("abort_pat",   32'(pat_o),       32'd0);
        check("abort_busy",  32'(busy_o),      32'd0);
        check("abort_pass",  32'(pass_o),      32'd0);
        check("abort_sig",   32'(sig_o),       32'h0001);
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            if (done_o) nd++;
            tick();
        end
        check("abort_no_done",    32'(nd),    32'd0);
        check("abort_sig_frozen", 32'(sig_o), 32'h0001);

        // Asynchronous reset in cycle 5 of a run
        seed_i = 10'h001; count_i = 10'd10; golden_i = 16'h03FF; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {pat_o, pat_valid_o, busy_o, done_o, pass_o, sig_o}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 15; c++) begin
            if (done_o) nd++;
            tick();
        end
        check("post_reset_no_done", 32'(nd), 32'd0);
        run(10'h001, 10'd2, 16'h0003, 0, f_p, l_p, np, dc, sd, pd, se, nd);
        check("post_reset_done_cyc", 32'(dc), 32'd4);
        check("post_reset_sig",      32'(sd), 32'h0003);
        check("post_reset_pass",     32'(pd), 32'd1);
        check("post_reset_seq_err",  32'(se), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
